lookup_stage: RTL

- One level of the pipelined tree-lookup engine. It consumes a key plus a node pointer and drives the read address of its stage node memory.
- It decodes the 72-bit node word returned one cycle later, picks the child branch by pivot comparison, and emits the pointer, result and flags that the next stage consumes.
- It accepts one lookup per cycle and has no stalls.

---
 rtl/lookup_stage_if.sv | 50 +++++
 rtl/lookup_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lookup_stage_if.sv
// Lookup stage bus: upstream lookup, node memory port, downstream result, stats.
// The environment drives through master; the stage itself uses slave.
interface lookup_stage_if #(
  parameter int DATA      = 72,
  parameter int ADDR      = 10,
  parameter int NEXT_ADDR = 11,
  parameter int KEY_W     = 16,
  parameter int TAG_W     = 8
);
  logic                 in_valid;
  logic [KEY_W-1:0]     in_key;
  logic [ADDR-1:0]      in_ptr;
  logic                 in_done;
  logic [11:0]          in_result;
  logic                 in_err;
  logic [TAG_W-1:0]     in_tag;
  logic [ADDR-1:0]      mem_addr;
  logic [DATA-1:0]      mem_rdata;
  logic                 out_valid;
  logic [KEY_W-1:0]     out_key;
  logic [NEXT_ADDR-1:0] out_ptr;
  logic                 out_done;
  logic [11:0]          out_result;
  logic                 out_err;
  logic [TAG_W-1:0]     out_tag;
  logic                 stat_clr;
  logic [31:0]          stat_lookups;
  logic [31:0]          stat_leaf;
  logic [31:0]          stat_err;

  modport master (
    output in_valid, in_key, in_ptr, in_done,
    output in_result, in_err, in_tag,
    output mem_rdata, stat_clr,
    input  mem_addr,
    input  out_valid, out_key, out_ptr, out_done,
    input  out_result, out_err, out_tag,
    input  stat_lookups, stat_leaf, stat_err
  );

  modport slave (
    input  in_valid, in_key, in_ptr, in_done,
    input  in_result, in_err, in_tag,
    input  mem_rdata, stat_clr,
    output mem_addr,
    output out_valid, out_key, out_ptr, out_done,
    output out_result, out_err, out_tag,
    output stat_lookups, stat_leaf, stat_err
  );
endinterface

// File: rtl/lookup_stage.sv
// One level of the pipelined tree lookup: S1 latches the request, S2 decodes the node.
// Optional statistics counters are built when LOOKUP_STATS_EN is defined.
module lookup_stage #(
  parameter int STAGE_ID  = 0,
  parameter int DATA      = 72,
  parameter int ADDR      = 10,
  parameter int NEXT_ADDR = 11,
  parameter int KEY_W     = 16,
  parameter int TAG_W     = 8
) (
  input logic           clk,
  input logic           rst,
  lookup_stage_if.slave bus
);

  logic [ADDR-1:0] w_addr;
  assign w_addr       = bus.in_ptr;
  assign bus.mem_addr = w_addr;

  logic             r_s1_valid;
  logic [KEY_W-1:0] r_s1_key;
  logic             r_s1_done;
  logic [11:0]      r_s1_result;
  logic             r_s1_err;
  logic [TAG_W-1:0] r_s1_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_key    <= '0;
      r_s1_done   <= 1'b0;
      r_s1_result <= '0;
      r_s1_err    <= 1'b0;
      r_s1_tag    <= '0;
    end else begin
      r_s1_valid  <= bus.in_valid;
      r_s1_key    <= bus.in_key;
      r_s1_done   <= bus.in_done;
      r_s1_result <= bus.in_result;
      r_s1_err    <= bus.in_err;
      r_s1_tag    <= bus.in_tag;
    end
  end

  logic [15:0] w_piv0, w_piv1, w_piv2;
  logic [11:0] w_base;
  logic [1:0]  w_npiv;
  logic        w_leaf;

  assign w_piv0 = bus.mem_rdata[15:0];
  assign w_piv1 = bus.mem_rdata[31:16];
  assign w_piv2 = bus.mem_rdata[47:32];
  assign w_base = bus.mem_rdata[59:48];
  assign w_npiv = bus.mem_rdata[61:60];
  assign w_leaf = bus.mem_rdata[62];

  logic [1:0]  w_idx;
  logic [12:0] w_sum;
  logic        w_range;

  // Pivots are counted, not assumed sorted.
  always_comb begin
    w_idx = 2'd0;
    if (w_npiv > 2'd0 && w_piv0 <= r_s1_key)
      w_idx = w_idx + 2'd1;
    if (w_npiv > 2'd1 && w_piv1 <= r_s1_key)
      w_idx = w_idx + 2'd1;
    if (w_npiv > 2'd2 && w_piv2 <= r_s1_key)
      w_idx = w_idx + 2'd1;
  end

  assign w_sum   = {1'b0, w_base} + {11'd0, w_idx};
  assign w_range = !w_leaf &&
    ({19'd0, w_sum} >= (32'd1 << NEXT_ADDR));

  logic [NEXT_ADDR-1:0] w_ptr;
  logic                 w_done;
  logic [11:0]          w_result;
  logic                 w_err;

  always_comb begin
    w_ptr    = '0;
    w_done   = 1'b1;
    w_result = r_s1_result;
    w_err    = r_s1_err;
    unique case (1'b1)
      r_s1_done: begin
        w_result = r_s1_result;
      end
      (!r_s1_done && w_leaf): begin
        w_result = w_sum[11:0];
      end
      (!r_s1_done && !w_leaf): begin
        w_done   = 1'b0;
        w_result = '0;
        w_err    = r_s1_err | w_range;
        w_ptr    = w_range ? '0 : w_sum[NEXT_ADDR-1:0];
      end
    endcase
  end

  logic                 r_out_valid;
  logic [KEY_W-1:0]     r_out_key;
  logic [NEXT_ADDR-1:0] r_out_ptr;
  logic                 r_out_done;
  logic [11:0]          r_out_result;
  logic                 r_out_err;
  logic [TAG_W-1:0]     r_out_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_key    <= '0;
      r_out_ptr    <= '0;
      r_out_done   <= 1'b0;
      r_out_result <= '0;
      r_out_err    <= 1'b0;
      r_out_tag    <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_key    <= r_s1_key;
        r_out_ptr    <= w_ptr;
        r_out_done   <= w_done;
        r_out_result <= w_result;
        r_out_err    <= w_err;
        r_out_tag    <= r_s1_tag;
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_key    = r_out_key;
  assign bus.out_ptr    = r_out_ptr;
  assign bus.out_done   = r_out_done;
  assign bus.out_result = r_out_result;
  assign bus.out_err    = r_out_err;
  assign bus.out_tag    = r_out_tag;

`ifdef LOOKUP_STATS_EN
  logic [31:0] r_stat_lookups;
  logic [31:0] r_stat_leaf;
  logic [31:0] r_stat_err;
  logic        w_cnt_lk;
  logic        w_cnt_leaf;
  logic        w_cnt_err;

  assign w_cnt_lk   = r_s1_valid && !r_s1_done;
  assign w_cnt_leaf = w_cnt_lk && w_leaf;
  assign w_cnt_err  = r_s1_valid && w_err && !r_s1_err;

  // Clear has priority; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || bus.stat_clr) begin
      r_stat_lookups <= '0;
      r_stat_leaf    <= '0;
      r_stat_err     <= '0;
    end else begin
      if (w_cnt_lk && r_stat_lookups != '1)
        r_stat_lookups <= r_stat_lookups + 32'd1;
      if (w_cnt_leaf && r_stat_leaf != '1)
        r_stat_leaf <= r_stat_leaf + 32'd1;
      if (w_cnt_err && r_stat_err != '1)
        r_stat_err <= r_stat_err + 32'd1;
    end
  end

  assign bus.stat_lookups = r_stat_lookups;
  assign bus.stat_leaf    = r_stat_leaf;
  assign bus.stat_err     = r_stat_err;

  logic w_unused;
  assign w_unused = ^{bus.mem_rdata[DATA-1:63],
                      STAGE_ID != 0};
`else
  assign bus.stat_lookups = '0;
  assign bus.stat_leaf    = '0;
  assign bus.stat_err     = '0;

  logic w_unused;
  assign w_unused = ^{bus.mem_rdata[DATA-1:63],
                      bus.stat_clr, STAGE_ID != 0};
`endif

endmodule
